// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM fade block: register offsets inside a
// bank, CTRL/CR/STATUS bit positions and the global-bank index helper.
package led_pwm_pkg;

    // Channel bank register offsets
    localparam logic [1:0] REG_DUTY   = 2'd0;
    localparam logic [1:0] REG_RATE   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CUR    = 2'd3;

    // Global bank register offsets
    localparam logic [1:0] REG_CR     = 2'd0;
    localparam logic [1:0] REG_PSL    = 2'd1;
    localparam logic [1:0] REG_PSH    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bits
    localparam int CTRL_EN      = 0;
    localparam int CTRL_INV     = 1;
    localparam int CTRL_FADE    = 2;
    localparam int CTRL_BREATHE = 3;

    // CR bits
    localparam int CR_RUN = 0;
    localparam int CR_IE  = 1;

    // STATUS period-end flag
    localparam int STATUS_PERIOD = 7;

    // The global bank is the all-ones bank of the address bank field.
    function automatic int unsigned glb_bank_idx(input int unsigned aw);
        return (32'd1 << (aw - 32'd2)) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: DUTY/RATE/CTRL registers, fade/breathe engine producing
// the applied duty CUR, and the registered compare output.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   wr_i, rsel_i       write strobe for this bank, register select
//   wdata_i            write data
//   run_i, pe_i        generator running, period-end strobe
//   cnt_i              shared PWM counter
//   rdata_o            read data for rsel_i
//   done_o             one-cycle pulse when a fade lands on its goal
//   pwm_o              registered channel output
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_i,
    input  logic [1:0]          rsel_i,
    input  logic [7:0]          wdata_i,
    input  logic                run_i,
    input  logic                pe_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    output logic [7:0]          rdata_o,
    output logic                done_o,
    output logic                pwm_o
);

    localparam logic [PWM_BITS-1:0] CUR_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] duty_q, cur_q, cur_d, goal;
    logic [7:0]          rate_q, rcnt_q, rcnt_d;
    logic [3:0]          ctrl_q;
    logic                dir_q, dir_d, pwm_q, raw;

    // dir_q=1 means a breathing channel is heading back down to zero.
    assign goal = (ctrl_q[CTRL_BREATHE] && dir_q) ? '0 : duty_q;

    always_comb begin
        cur_d  = cur_q;
        rcnt_d = rcnt_q;
        dir_d  = ctrl_q[CTRL_BREATHE] ? dir_q : 1'b0;
        done_o = 1'b0;
        if (!ctrl_q[CTRL_FADE]) begin
            rcnt_d = '0;
        end
        if (pe_i) begin
            if (!ctrl_q[CTRL_FADE]) begin
                cur_d = goal;
                if (ctrl_q[CTRL_BREATHE]) begin
                    dir_d = ~dir_q;
                end
            end else if (rcnt_q == rate_q) begin
                rcnt_d = '0;
                if (cur_q < goal) begin
                    cur_d = cur_q + CUR_ONE;
                end else if (cur_q > goal) begin
                    cur_d = cur_q - CUR_ONE;
                end
                done_o = (cur_q != goal) && (cur_d == goal);
                if (ctrl_q[CTRL_BREATHE] && (cur_d == goal)) begin
                    dir_d = ~dir_q;
                end
            end else begin
                rcnt_d = rcnt_q + 8'd1;
            end
        end
    end

    // A stopped generator parks the output at its idle (inv) level.
    assign raw = run_i & ctrl_q[CTRL_EN] & (cnt_i < cur_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q <= '0;
            rate_q <= '0;
            ctrl_q <= '0;
            cur_q  <= '0;
            rcnt_q <= '0;
            dir_q  <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            if (wr_i) begin
                case (rsel_i)
                    REG_DUTY: duty_q <= wdata_i[PWM_BITS-1:0];
                    REG_RATE: rate_q <= wdata_i;
                    REG_CTRL: ctrl_q <= wdata_i[3:0];
                    default: ;
                endcase
            end
            cur_q  <= cur_d;
            rcnt_q <= rcnt_d;
            dir_q  <= dir_d;
            pwm_q  <= raw ^ ctrl_q[CTRL_INV];
        end
    end

    always_comb begin
        rdata_o = '0;
        case (rsel_i)
            REG_DUTY: rdata_o[PWM_BITS-1:0] = duty_q;
            REG_RATE: rdata_o = rate_q;
            REG_CTRL: rdata_o[3:0] = ctrl_q;
            default:  rdata_o[PWM_BITS-1:0] = cur_q;
        endcase
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_fade.sv
// Multi-channel LED PWM generator with per-channel fade/breathe engines on
// the 8-bit CPU register bus.
// Ports:
//   clk, rst         system clock, async active-low reset
//   cs, we, addr     bus strobe, write enable, {bank, reg} select
//   din, dout        write data, registered read data (1-cycle latency)
//   pwm              channel outputs, bit i = channel i
//   irq              level interrupt, any pending fade completion with CR.ie
module led_pwm_fade
    import led_pwm_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int PWM_BITS = 8,
    parameter int AW       = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic [NCH-1:0] pwm,
    output logic           irq
);

    localparam int unsigned         GLB_IDX    = glb_bank_idx(AW);
    localparam logic [AW-3:0]       GLB_BANK   = GLB_IDX[AW-3:0];
    localparam int unsigned         CNT_LAST_I = (1 << PWM_BITS) - 2;
    localparam logic [PWM_BITS-1:0] CNT_LAST   = CNT_LAST_I[PWM_BITS-1:0];

    logic [AW-3:0]       bank;
    logic [1:0]          rsel;
    logic                wr, rd, glb_hit;
    logic [1:0]          cr_q;
    logic [7:0]          psl_q, psh_q, dout_q, rd_data, status_rd;
    logic [15:0]         ps_cnt_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic                tick, pe;
    logic [NCH-1:0]      pend_q, pend_d, ch_hit, ch_done;
    logic                flag_q, flag_d;
    logic [7:0]          ch_rd [NCH];

    assign bank    = addr[AW-1:2];
    assign rsel    = addr[1:0];
    assign wr      = cs & we;
    assign rd      = cs & ~we;
    assign glb_hit = (bank == GLB_BANK);

    // Prescaler reloads from {PSH,PSL} on each tick, so a new value written
    // while running is picked up at the next reload.
    assign tick = cr_q[CR_RUN] && (ps_cnt_q == 16'd0);
    assign pe   = tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt_q <= '0;
            cnt_q    <= '0;
        end else if (!cr_q[CR_RUN]) begin
            ps_cnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            ps_cnt_q <= tick ? {psh_q, psl_q} : ps_cnt_q - 16'd1;
            if (tick) begin
                cnt_q <= pe ? '0 : cnt_q + PWM_BITS'(1);
            end
        end
    end

    // Clears are applied first so a same-cycle set survives.
    always_comb begin
        pend_d = pend_q;
        flag_d = flag_q;
        if (wr && glb_hit && (rsel == REG_STATUS)) begin
            pend_d = pend_q & ~din[NCH-1:0];
            flag_d = flag_q & ~din[STATUS_PERIOD];
        end
        pend_d = pend_d | ch_done;
        if (pe) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_q   <= '0;
            psl_q  <= '0;
            psh_q  <= '0;
            pend_q <= '0;
            flag_q <= 1'b0;
            dout_q <= '0;
        end else begin
            if (wr && glb_hit) begin
                case (rsel)
                    REG_CR:  cr_q  <= din[1:0];
                    REG_PSL: psl_q <= din;
                    REG_PSH: psh_q <= din;
                    default: ;
                endcase
            end
            pend_q <= pend_d;
            flag_q <= flag_d;
            if (rd) begin
                dout_q <= rd_data;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        localparam int unsigned   CI      = c;
        localparam logic [AW-3:0] BANK_ID = CI[AW-3:0];
        assign ch_hit[c] = (bank == BANK_ID);
        led_pwm_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk_i   (clk),
            .rst_ni  (rst),
            .wr_i    (wr & ch_hit[c]),
            .rsel_i  (rsel),
            .wdata_i (din),
            .run_i   (cr_q[CR_RUN]),
            .pe_i    (pe),
            .cnt_i   (cnt_q),
            .rdata_o (ch_rd[c]),
            .done_o  (ch_done[c]),
            .pwm_o   (pwm[c])
        );
    end

    always_comb begin
        status_rd                = '0;
        status_rd[NCH-1:0]       = pend_q;
        status_rd[STATUS_PERIOD] = flag_q;
    end

    always_comb begin
        rd_data = '0;
        if (glb_hit) begin
            case (rsel)
                REG_CR:  rd_data = {6'b0, cr_q};
                REG_PSL: rd_data = psl_q;
                REG_PSH: rd_data = psh_q;
                default: rd_data = status_rd;
            endcase
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_hit[i]) begin
                    rd_data = ch_rd[i];
                end
            end
        end
    end

    assign dout = dout_q;
    assign irq  = cr_q[CR_IE] & (|pend_q);

endmodule
